// File: rtl/hamming_pkg.sv
// Shared types and constants for the SEC-DED (16,11) encoder/decoder pair.
// The syndrome helper is kept here so the encoder bench can reuse it.
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        FIX,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [1:0] FLG_OK  = 2'b00;
    localparam logic [1:0] FLG_ONE = 2'b01;
    localparam logic [1:0] FLG_TWO = 2'b10;

    localparam int NUM_MSGS_DEF = 15;
    localparam int SRC_BASE_DEF = 30;
    localparam int DST_BASE_DEF = 0;
    localparam int ADDR_W_DEF   = 8;

    // XOR of the position numbers of every set bit in positions 1..15.
    function automatic logic [3:0] syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) s = s ^ 4'(k);
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming_secded_fix.sv
// Combinational SEC-DED check: computes syndrome and overall parity,
// corrects a single flipped bit and extracts the 11 data bits.
module hamming_secded_fix
    import hamming_pkg::*;
(
    input  logic [15:0] w,
    output logic [11:1] d,
    output logic [1:0]  f
);

    logic [3:0]  s;
    logic        p;
    logic [15:0] wc;

    always_comb begin
        s  = syndrome(w);
        p  = ^w;
        wc = w;
        f  = FLG_OK;
        if (p) begin
            // s==0 with odd parity means p0 itself flipped; data is intact.
            f = FLG_ONE;
            if (s != 4'd0) wc[s] = ~w[s];
        end else if (s != 4'd0) begin
            f = FLG_TWO;
        end
        d = {wc[15:9], wc[7:5], wc[3]};
    end

endmodule

// File: rtl/hamming_decoder.sv
// Memory-walking SEC-DED decoder: reads encoded words from the source area,
// writes corrected data plus status flags to the destination area.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RD_LO | read low byte of encoded word i
//   RD_HI | read high byte of encoded word i
//   FIX   | register corrected data and flags
//   WR_LO | write data bits d8..d1
//   WR_HI | write flags and d11..d9, advance i
//   DONE  | run complete, done held high until next start
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int NUM_MSGS = NUM_MSGS_DEF,
    parameter int SRC_BASE = SRC_BASE_DEF,
    parameter int DST_BASE = DST_BASE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_dat,
    input  logic [7:0]        mem_rd_dat
);

    localparam int IDX_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MSGS - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [15:0]       w;
    logic [11:1]       fix_d, res_d;
    logic [1:0]        fix_f, res_f;
    logic              wr_req;
    logic [ADDR_W-1:0] ofs, src_lo, dst_lo;

    assign ofs    = ADDR_W'(idx) << 1;
    assign src_lo = ADDR_W'(SRC_BASE) + ofs;
    assign dst_lo = ADDR_W'(DST_BASE) + ofs;

    hamming_secded_fix u_fix (
        .w (w),
        .d (fix_d),
        .f (fix_f)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            w     <= '0;
            res_d <= '0;
            res_f <= FLG_OK;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == RD_LO) w[7:0]  <= mem_rd_dat;
            if (state == RD_HI) w[15:8] <= mem_rd_dat;
            if (state == FIX) begin
                res_d <= fix_d;
                res_f <= fix_f;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        mem_addr   = '0;
        mem_wr_dat = '0;
        wr_req     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    idx_nxt   = '0;
                    state_nxt = RD_LO;
                end
            end
            RD_LO: begin
                mem_addr  = src_lo;
                state_nxt = RD_HI;
            end
            RD_HI: begin
                mem_addr  = src_lo + ADDR_W'(1);
                state_nxt = FIX;
            end
            FIX: begin
                state_nxt = WR_LO;
            end
            WR_LO: begin
                mem_addr   = dst_lo;
                mem_wr_dat = res_d[8:1];
                wr_req     = 1'b1;
                state_nxt  = WR_HI;
            end
            WR_HI: begin
                mem_addr   = dst_lo + ADDR_W'(1);
                mem_wr_dat = {res_f, 3'b000, res_d[11:9]};
                wr_req     = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = RD_LO;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset masks the strobe so the write landing on the reset edge is dropped.
    assign mem_wr_en = wr_req & ~reset;
    assign done      = (state == DONE);

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder with a byte-wide memory model;
// expected bytes are hand-decoded constants per slot.
module tb_hamming_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_dat;
    logic [7:0] mem_rd_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int src_wr  = 0;

    logic [7:0]  mem    [256];
    logic [15:0] src    [15];
    logic [7:0]  exp_lo [15];
    logic [7:0]  exp_hi [15];

    always #5 clk = ~clk;

    hamming_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_dat (mem_wr_dat),
        .mem_rd_dat (mem_rd_dat)
    );

    assign mem_rd_dat = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_dat;
            wr_cnt++;
            if (mem_addr >= 8'd30) src_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_clean();
        for (int i = 0; i < 15; i++) begin
            src[i]    = 16'h000F;
            exp_lo[i] = 8'h01;
            exp_hi[i] = 8'h00;
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 15; i++) begin
            mem[30 + 2*i] = src[i][7:0];
            mem[31 + 2*i] = src[i][15:8];
        end
        for (int j = 0; j < 30; j++) mem[j] = 8'hAA;
        wr_cnt = 0;
        src_wr = 0;
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run_wait(input int extra_at);
        int cyc;
        start_run();
        cyc = 1;
        check("done_clr", done, 0);
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_at);
        end
        start = 1'b0;
        check("done_lat", cyc, 76);
    endtask

    task automatic check_out();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("lo%0d", i), mem[2*i],     exp_lo[i]);
            check($sformatf("hi%0d", i), mem[2*i + 1], exp_hi[i]);
        end
        check("wr_cnt", wr_cnt, 30);
        check("src_wr", src_wr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_clean();
        load_mem();
        repeat (3) @(negedge clk);
        check("rst_done",   done,       0);
        check("rst_wr_en",  mem_wr_en,  0);
        check("rst_addr",   mem_addr,   0);
        check("rst_wr_dat", mem_wr_dat, 0);
        reset = 1'b0;

        // single data error, double error, p0-only error; extra start ignored
        src[0]  = 16'h040F; exp_hi[0] = 8'h40;
        src[3]  = 16'h042F; exp_lo[3] = 8'h23; exp_hi[3] = 8'h80;
        src[14] = 16'h000E; exp_hi[14] = 8'h40;
        load_mem();
        run_wait(20);
        check_out();
        check("src58", mem[58], 8'h0E);
        check("src59", mem[59], 8'h00);

        repeat (5) @(negedge clk);
        check("done_hold", done, 1);

        // all-ones data, error on w[15], error on p8; restart from DONE
        set_clean();
        src[1] = 16'hFFFF; exp_lo[1] = 8'hFF; exp_hi[1] = 8'h07;
        src[2] = 16'h7FFF; exp_lo[2] = 8'hFF; exp_hi[2] = 8'h47;
        src[5] = 16'h010F; exp_lo[5] = 8'h01; exp_hi[5] = 8'h40;
        load_mem();
        run_wait(0);
        check_out();

        // reset during WR_LO of message 5 (cycle 29)
        load_mem();
        start_run();
        repeat (28) @(negedge clk);
        check("pre_rst_addr", mem_addr, 10);
        reset = 1'b1;
        #1;
        check("rst_cyc_wr_en", mem_wr_en, 0);
        @(negedge clk);
        check("post_rst_done",  done,      0);
        check("post_rst_wr_en", mem_wr_en, 0);
        check("post_rst_addr",  mem_addr,  0);
        reset = 1'b0;
        check("keep9",  mem[9],  8'h00);
        check("skip10", mem[10], 8'hAA);
        check("part_wr", wr_cnt, 10);
        wr_cnt = 0;
        src_wr = 0;
        run_wait(0);
        check_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
- Hardware stage directly downstream of the program-1 Hamming encoder.
- Walks data memory and reads 15 encoded 16-bit words (SEC-DED (16,11), parity inserted) from bytes 30..59.
- Corrects single-bit errors and flags double errors.
- Writes the 11-bit messages plus 2-bit status to bytes 0..29.
- Shares the data-memory port with the core under a start/done handshake.

Parameters:
- NUM_MSGS, 15, number of encoded words processed per run.
- SRC_BASE, 30, byte address of first encoded word (low byte).
- DST_BASE, 0, byte address of first decoded output (low byte).
- ADDR_W, 8, data-memory byte-address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; forces IDLE.
- start  input  1  request; sampled only in IDLE.
- done  output  1  high from run completion until next accepted start or reset.
- mem_addr  output  ADDR_W  byte address to data memory.
- mem_wr_en  output  1  write strobe; memory writes mem_wr_dat on the rising edge while high.
- mem_wr_dat  output  8  write byte.
- mem_rd_dat  input  8  combinational read of the byte at mem_addr, valid in the same cycle.

Behaviour:
- Reset values: done=0, mem_wr_en=0, mem_addr=0, mem_wr_dat=0, msg index i=0, state=IDLE.
- States: IDLE -> RD_LO -> RD_HI -> FIX -> WR_LO -> WR_HI -> (i==NUM_MSGS-1 ? DONE : RD_LO with i+1). DONE -> RD_LO with i=0 on start, else stay.
- IDLE: start=1 clears done and i, then goes to RD_LO next cycle.
- RD_LO: mem_addr=SRC_BASE+2i; latch mem_rd_dat into w[7:0].
- RD_HI: mem_addr=SRC_BASE+2i+1; latch into w[15:8].
- FIX: no memory access, mem_wr_en=0; register the corrected result.
- WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1.
- WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1.
- Timing: 5 cycles per message. done rises exactly 1+5*NUM_MSGS = 76 cycles after the start-sampling edge.
- Word layout: w[k] is Hamming position k for k=1..15; w[0]=p0 (overall parity).
  - p1=w[1], p2=w[2], p4=w[4], p8=w[8].
  - data: d1=w[3], d4..d2=w[7:5], d11..d5=w[15:9].
- Syndrome s[3:0] = XOR of all k in 1..15 with w[k]=1. P = ^w[15:0].
- Decode cases:
  - s==0, P==0: no error, F=2'b00.
  - P==1: single error, F=2'b01. If s!=0, invert w[s] before extraction; if s==0, p0 was the bad bit and data is unchanged.
  - s!=0, P==0: double error, F=2'b10, data extracted uncorrected.
  - F=2'b11 is never produced.
- Output bytes:
  - low = {d8,d7,d6,d5,d4,d3,d2,d1}.
  - high = {F[1],F[0],3'b000,d11,d10,d9}.
- Boundaries:
  - start while not in IDLE/DONE is ignored.
  - reset mid-run returns to IDLE within one edge; no write occurs in the reset cycle; partially written outputs stay in memory.
  - Source bytes are never written.
  - Address arithmetic is modulo 2^ADDR_W.
  - Outside WR_LO/WR_HI, mem_wr_en=0.

Decomposition:
- Shared package hamming_pkg:
  - state enum (IDLE, RD_LO, RD_HI, FIX, WR_LO, WR_HI, DONE).
  - 2-bit flag constants (FLG_OK=00, FLG_ONE=01, FLG_TWO=10).
  - SRC_BASE/DST_BASE defaults.
  - also used by the encoder bench.
- One combinational sub-module hamming_secded_fix:
  - input w[15:0].
  - outputs d[11:1], F[1:0].
  - instantiated once; holds syndrome, correction and extraction logic.
- FSM, index counter and memory muxing live in hamming_decoder.

Test Plan:
- Clean word: all slots 0x000F (d=11'h001), start -> after 76 cycles done=1; each output pair lo=0x01, hi=0x00.
- Single data error: slot 0 = 0x040F (w[10] flipped) -> lo=0x01, hi=0x40; the other 14 slots (clean 0x000F) give 0x01/0x00.
- Double error: slot 3 = 0x042F (w[10], w[5] flipped) -> bytes 6/7 = 0x23/0x80 (uncorrected data, F=10).
- p0-only error: slot 14 = 0x000E -> bytes 28/29 = 0x01/0x40; bytes 58/59 still 0x0E/0x00.
- Handshake: second start pulse at cycle 20 of a run -> ignored, done still at cycle 76; start after done -> done drops next cycle, rerun completes 76 cycles later.
- Reset mid-run: assert reset during the WR_LO of message 5 -> that write suppressed, done=0, mem_wr_en=0 next cycle; a fresh start then fully rewrites bytes 0..29.
